// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
// ---------------------------------------------------------------------------
// Circular byte FIFO placed directly in front of the UART transmitter. User
// bytes arrive in bursts on a valid/ready write port. They leave in order on a
// valid/ready stream that connects straight to the transmitter's data, valid
// and ready signals.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous reset, active low (0 = in reset)
//   i_flush        synchronous clear of contents and sticky overflow flag
//   i_wr_data      user write data
//   i_wr_valid     user write request
//   o_wr_ready     registered, equals !full; a write happens on valid & ready
//   o_tx_data      head word, held stable while o_tx_valid waits for ready
//   o_tx_valid     head word valid
//   i_tx_ready     transmitter ready; a transfer happens on valid & ready
//   o_count        occupancy, 0..P_FIFO_DEPTH
//   o_empty        o_count == 0
//   o_full         o_count == P_FIFO_DEPTH
//   o_almost_full  o_count >= P_ALMOST_FULL
//   o_overflow     sticky: a write was attempted while full
//
// Organisation
//   Accepted words are stored in an inferred RAM. A registered read moves the
//   head word out of the RAM into an output register (o_tx_data/o_tx_valid).
//   o_count is the total occupancy, which includes the word held in the output
//   register. The number of words still waiting in the RAM is
//   count - tx_valid.
// ---------------------------------------------------------------------------
module uart_tx_buffer #(
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_FIFO_DEPTH  = 16,
    parameter int P_ALMOST_FULL = 12
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic [P_DATA_WIDTH-1:0]         i_wr_data,
    input  logic                            i_wr_valid,
    output logic                            o_wr_ready,
    output logic [P_DATA_WIDTH-1:0]         o_tx_data,
    output logic                            o_tx_valid,
    input  logic                            i_tx_ready,
    output logic [$clog2(P_FIFO_DEPTH):0]   o_count,
    output logic                            o_empty,
    output logic                            o_full,
    output logic                            o_almost_full,
    output logic                            o_overflow
);

    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(P_FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(P_ALMOST_FULL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Storage; no reset so it maps onto block RAM.
    logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];

    logic [AW-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]           count_reg, count_next;
    logic                    tx_valid_reg, tx_valid_next;
    logic [P_DATA_WIDTH-1:0] tx_data_reg;
    logic                    overflow_reg, overflow_next;
    logic                    wr_ready_reg, empty_reg, full_reg, afull_reg;

    logic                    wr_fire;
    logic                    rd_fire;
    logic                    load;
    logic [CW-1:0]           pending;

    // wr_ready_reg is a register, so a write offered while full is dropped
    // even if the transmitter takes a word on the same edge.
    assign wr_fire = i_wr_valid & wr_ready_reg;
    assign rd_fire = tx_valid_reg & i_tx_ready;

    // Words sitting in the RAM that are not yet in the output register.
    assign pending = count_reg - {{AW{1'b0}}, tx_valid_reg};

    // Refill the output register when it is empty or is being emptied this
    // edge. Only words already in the RAM before this edge qualify. This
    // gives the one-cycle fall-through and still allows back-to-back
    // transfers.
    assign load = (pending != '0) && (!tx_valid_reg || rd_fire);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        tx_valid_next = tx_valid_reg;
        overflow_next = overflow_reg;

        if (i_flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            tx_valid_next = 1'b0;
            overflow_next = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (load) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            unique case ({wr_fire, rd_fire})
                2'b10:   count_next = count_reg + ONE_C;
                2'b01:   count_next = count_reg - ONE_C;
                default: count_next = count_reg;
            endcase
            tx_valid_next = load | (tx_valid_reg & ~rd_fire);
            if (i_wr_valid && full_reg) begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_fire && !i_flush) begin
            mem[wr_ptr_reg] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            overflow_reg <= 1'b0;
            wr_ready_reg <= 1'b1;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            afull_reg    <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            tx_valid_reg <= tx_valid_next;
            overflow_reg <= overflow_next;
            // Flags are derived from the next count so they line up with
            // o_count in the same cycle.
            wr_ready_reg <= (count_next != DEPTH_C);
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next == DEPTH_C);
            afull_reg    <= (count_next >= AFULL_C);
            if (i_flush) begin
                tx_data_reg <= '0;
            end else if (load) begin
                tx_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign o_wr_ready    = wr_ready_reg;
    assign o_tx_data     = tx_data_reg;
    assign o_tx_valid    = tx_valid_reg;
    assign o_count       = count_reg;
    assign o_empty       = empty_reg;
    assign o_full        = full_reg;
    assign o_almost_full = afull_reg;
    assign o_overflow    = overflow_reg;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer.
// Model: a queue of accepted words, each tagged with the edge index at which it
// was written. After edge E, the head is visible when it was written before E.
module tb_uart_tx_buffer;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int CW     = 5;
    localparam int TX_GAP = 60;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic          wr_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          afull;
    logic          ovf;

    uart_tx_buffer #(
        .P_DATA_WIDTH (DW),
        .P_FIFO_DEPTH (DEPTH),
        .P_ALMOST_FULL(AF)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_flush      (flush),
        .i_wr_data    (wr_data),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_count      (count),
        .o_empty      (empty),
        .o_full       (full),
        .o_almost_full(afull),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } ent_t;

    ent_t q[$];
    int   edge_n = 0;
    bit   m_valid = 1'b0;
    bit   m_ovf = 1'b0;
    bit   m_full_before = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model update and per-cycle comparison.
    always @(posedge clk) begin
        edge_n++;
        if (!rst_n || flush) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            m_full_before = (q.size() == DEPTH);
            if (m_valid && tx_ready) begin
                void'(q.pop_front());
            end
            if (wr_valid) begin
                if (!m_full_before) q.push_back('{d: wr_data, e: edge_n});
                else                m_ovf = 1'b1;
            end
        end
        m_valid = (q.size() > 0) && (q[0].e < edge_n);
        #1;
        chk("m_count",    int'(count),    q.size());
        chk("m_empty",    int'(empty),    int'(q.size() == 0));
        chk("m_full",     int'(full),     int'(q.size() == DEPTH));
        chk("m_afull",    int'(afull),    int'(q.size() >= AF));
        chk("m_wr_ready", int'(wr_ready), int'(q.size() != DEPTH));
        chk("m_tx_valid", int'(tx_valid), int'(m_valid));
        chk("m_overflow", int'(ovf),      int'(m_ovf));
        if (m_valid)     chk("m_tx_data", int'(tx_data), int'(q[0].d));
        else if (!rst_n) chk("m_rst_data", int'(tx_data), 0);
    end

    task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rdy, input bit fl);
        wr_valid = wv;
        wr_data  = wd;
        tx_ready = rdy;
        flush    = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx_valid"}, int'(tx_valid), 0);
        chk({tag, "_tx_data"},  int'(tx_data),  0);
        chk({tag, "_wr_ready"}, int'(wr_ready), 1);
        chk({tag, "_empty"},    int'(empty),    1);
        chk({tag, "_full"},     int'(full),     0);
        chk({tag, "_afull"},    int'(afull),    0);
        chk({tag, "_ovf"},      int'(ovf),      0);
        chk({tag, "_count"},    int'(count),    0);
    endtask

    logic [DW-1:0] hold;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_reset_values("por");
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // 1. single byte with one-cycle fall-through
        drive(1'b1, 8'h0A, 1'b1, 1'b0);
        chk("t1_count_after_wr", int'(count), 1);
        chk("t1_valid_after_wr", int'(tx_valid), 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_valid", int'(tx_valid), 1);
        chk("t1_data", int'(tx_data), 8'h0A);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_count_end", int'(count), 0);
        chk("t1_empty_end", int'(empty), 1);
        $display("t1 single byte done");

        // 2. fill 0x00..0x0F with the transmitter stalled
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            chk("t2_afull", int'(afull), int'(i + 1 >= AF));
        end
        chk("t2_full", int'(full), 1);
        chk("t2_wr_ready", int'(wr_ready), 0);
        chk("t2_count", int'(count), 16);

        // 3. overflow while full, then a dropped write alongside a read
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("t3_ovf", int'(ovf), 1);
        chk("t3_count", int'(count), 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_order_valid", int'(tx_valid), 1);
            chk("t2_order_data", int'(tx_data), i);
            drive(i == 0, 8'hBB, 1'b1, 1'b0);
            if (i == 0) chk("t3_drop_on_read", int'(count), 15);
        end
        chk("t2_drained", int'(count), 0);
        chk("t3_ovf_sticky", int'(ovf), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_flush_ovf", int'(ovf), 0);
        chk("t3_flush_count", int'(count), 0);
        chk("t3_flush_ready", int'(wr_ready), 1);
        $display("t2/t3 fill, order, overflow, flush done");

        // 4. simultaneous write and read at count 5, then random mix across wrap
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("t4_count5", int'(count), 5);
        chk("t4_valid", int'(tx_valid), 1);
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        chk("t4_simul_count", int'(count), 5);
        for (int i = 0; i < 40; i++)
            drive(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 40 && !empty; k++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_drain_empty", int'(empty), 1);
        $display("t4 simultaneous and mixed done");

        // 5. transmitter-style backpressure: long low, one-cycle high
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            hold = tx_data;
            repeat (TX_GAP) drive(1'b0, 8'h00, 1'b0, 1'b0);
            chk("t5_stable", int'(tx_data), int'(hold));
            chk("t5_data", int'(tx_data), 8'hC1 + b);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t5_consumed_once", int'(count), 2 - b);
        end
        $display("t5 backpressure done");

        // 6. asynchronous reset mid-burst
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("t6_count7", int'(count), 7);
        chk("t6_valid", int'(tx_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("t6_async");
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_first_valid", int'(tx_valid), 1);
        chk("t6_first_data", int'(tx_data), 8'h55);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        $display("t6 reset mid-burst done");

        // Random soak with occasional flush
        for (int i = 0; i < 400; i++)
            drive(bit'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 49) == 0));
        for (int k = 0; k < 40 && !empty; k++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("soak_drain_empty", int'(empty), 1);
        $display("random soak done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
